dm_axi_master: RTL and testbench

- Data-memory AXI master for the MEM stage. Turns MEM-stage load/store requests into single-beat AXI transactions.
- Publishes the completed transaction's tag: address, data, byte-enables and a valid flag. The hazard-detection stage compares this tag against the MEM-stage request and holds stall_axi_dm until they match.
- Valid flags clear when the pipeline advances, so back-to-back accesses to the same address are re-issued.

---
 rtl/dm_axi_master.sv | 235 +++++++++++++++++++++++
 tb/tb_dm_axi_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_axi_master.sv
// MEM-stage data-memory AXI master: one single-beat read or write outstanding; completed tags feed hazard compare.
// Zero-wait slave gives tag valid 3 cycles after request; every AXI channel stalls on its own ready/valid.
module dm_axi_master #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_mem_read_i,
    input  logic            mem_mem_store_i,
    input  logic [31:0]     mem_alu_result_i,
    input  logic [31:0]     mem_mem_wdata_i,
    input  logic [3:0]      mem_mem_web_i,
    input  logic            pipe_advance_i,
    output logic [31:0]     axi_raddr_o,
    output logic [31:0]     axi_rdata_o,
    output logic            axi_rvalid_o,
    output logic [31:0]     axi_waddr_o,
    output logic [31:0]     axi_wdata_o,
    output logic [3:0]      axi_web_o,
    output logic            axi_wvalid_o,
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [3:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY,
    output logic [ID_W-1:0] AWID,
    output logic [31:0]     AWADDR,
    output logic [3:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,
    output logic [31:0]     WDATA,
    output logic [3:0]      WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [3:0]  web_q, web_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] rtag_addr_q, rtag_addr_d;
    logic [31:0] rtag_data_q, rtag_data_d;
    logic        rtag_vld_q, rtag_vld_d;
    logic [31:0] wtag_addr_q, wtag_addr_d;
    logic [31:0] wtag_data_q, wtag_data_d;
    logic [3:0]  wtag_web_q, wtag_web_d;
    logic        wtag_vld_q, wtag_vld_d;

    logic rd_hit;
    logic wr_hit;
    logic aw_done;
    logic w_done;

    // Response IDs, codes and RLAST carry no information with a single outstanding beat.
    logic unused_inputs;
    assign unused_inputs = ^{RID, RRESP, RLAST, BID, BRESP};

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        web_d       = web_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        rtag_addr_d = rtag_addr_q;
        rtag_data_d = rtag_data_q;
        wtag_addr_d = wtag_addr_q;
        wtag_data_d = wtag_data_q;
        wtag_web_d  = wtag_web_q;
        rtag_vld_d  = pipe_advance_i ? 1'b0 : rtag_vld_q;
        wtag_vld_d  = pipe_advance_i ? 1'b0 : wtag_vld_q;

        rd_hit  = rtag_vld_q && (rtag_addr_q == mem_alu_result_i);
        wr_hit  = wtag_vld_q && (wtag_addr_q == mem_alu_result_i) &&
                  (wtag_data_q == mem_mem_wdata_i) && (wtag_web_q == mem_mem_web_i);
        aw_done = !awvalid_q || AWREADY;
        w_done  = !wvalid_q || WREADY;

        case (state_q)
            IDLE: begin
                if (mem_mem_read_i && !rd_hit) begin
                    araddr_d  = mem_alu_result_i;
                    arvalid_d = 1'b1;
                    state_d   = RD_ADDR;
                end else if (mem_mem_store_i && !wr_hit) begin
                    awaddr_d  = mem_alu_result_i;
                    wdata_d   = mem_mem_wdata_i;
                    wstrb_d   = ~mem_mem_web_i;
                    web_d     = mem_mem_web_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_REQ;
                end
            end
            RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    rtag_addr_d = araddr_q;
                    rtag_data_d = RDATA;
                    rtag_vld_d  = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; move on once neither is pending.
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    wtag_addr_d = awaddr_q;
                    wtag_data_d = wdata_q;
                    wtag_web_d  = web_q;
                    wtag_vld_d  = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            araddr_q    <= 32'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= 32'd0;
            awvalid_q   <= 1'b0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            web_q       <= 4'hF;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rtag_addr_q <= 32'd0;
            rtag_data_q <= 32'd0;
            rtag_vld_q  <= 1'b0;
            wtag_addr_q <= 32'd0;
            wtag_data_q <= 32'd0;
            wtag_web_q  <= 4'hF;
            wtag_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            web_q       <= web_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rtag_addr_q <= rtag_addr_d;
            rtag_data_q <= rtag_data_d;
            rtag_vld_q  <= rtag_vld_d;
            wtag_addr_q <= wtag_addr_d;
            wtag_data_q <= wtag_data_d;
            wtag_web_q  <= wtag_web_d;
            wtag_vld_q  <= wtag_vld_d;
        end
    end

    assign ARID    = AXI_ID;
    assign ARADDR  = araddr_q;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

    assign AWID    = AXI_ID;
    assign AWADDR  = awaddr_q;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = awvalid_q;

    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

    assign axi_raddr_o  = rtag_addr_q;
    assign axi_rdata_o  = rtag_data_q;
    assign axi_rvalid_o = rtag_vld_q;
    assign axi_waddr_o  = wtag_addr_q;
    assign axi_wdata_o  = wtag_data_q;
    assign axi_web_o    = wtag_web_q;
    assign axi_wvalid_o = wtag_vld_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master: reactive AXI slave plus a scoreboard that checks handshakes and published tags.
module tb_dm_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_mem_read_i, mem_mem_store_i, pipe_advance_i;
    logic [31:0] mem_alu_result_i, mem_mem_wdata_i;
    logic [3:0]  mem_mem_web_i;
    logic [31:0] axi_raddr_o, axi_rdata_o, axi_waddr_o, axi_wdata_o;
    logic [3:0]  axi_web_o;
    logic        axi_rvalid_o, axi_wvalid_o;
    logic [3:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    dm_axi_master #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .mem_mem_read_i(mem_mem_read_i), .mem_mem_store_i(mem_mem_store_i),
        .mem_alu_result_i(mem_alu_result_i), .mem_mem_wdata_i(mem_mem_wdata_i),
        .mem_mem_web_i(mem_mem_web_i), .pipe_advance_i(pipe_advance_i),
        .axi_raddr_o(axi_raddr_o), .axi_rdata_o(axi_rdata_o), .axi_rvalid_o(axi_rvalid_o),
        .axi_waddr_o(axi_waddr_o), .axi_wdata_o(axi_wdata_o), .axi_web_o(axi_web_o),
        .axi_wvalid_o(axi_wvalid_o),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues, filled by the stimulus thread.
    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [63:0] exp_r[$];
    logic [67:0] exp_b[$];

    // Slave knobs.
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic        r_en = 1'b1;
    logic [31:0] r_data = 32'd0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0;

    // Slave drives at negedge+1 for the coming posedge.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
            RVALID  = 1'b0; BVALID  = 1'b0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            ARREADY = ARVALID && (ar_cnt >= ar_delay);
            ar_cnt  = ARVALID ? ar_cnt + 1 : 0;
            AWREADY = AWVALID && (aw_cnt >= aw_delay);
            aw_cnt  = AWVALID ? aw_cnt + 1 : 0;
            WREADY  = WVALID && (w_cnt >= w_delay);
            w_cnt   = WVALID ? w_cnt + 1 : 0;
            RVALID  = RREADY && r_en;
            RDATA   = r_data;
            BVALID  = BREADY;
        end
    end

    // Monitor: sees the values the DUT will sample at the next posedge.
    logic prev_rv = 1'b0, prev_wv = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e32;
        logic [35:0] e36;
        logic [63:0] e64;
        logic [67:0] e68;
        #2;
        if (!rst) begin
            if (ARVALID && ARREADY) begin
                ar_hs++;
                if (exp_ar.size() == 0) chk("unexpected_ar", ARADDR, 32'hFFFF_FFFF);
                else begin e32 = exp_ar.pop_front(); chk("araddr", ARADDR, e32); end
            end
            if (AWVALID && AWREADY) begin
                aw_hs++;
                if (exp_aw.size() == 0) chk("unexpected_aw", AWADDR, 32'hFFFF_FFFF);
                else begin e32 = exp_aw.pop_front(); chk("awaddr", AWADDR, e32); end
            end
            if (WVALID && WREADY) begin
                w_hs++;
                if (exp_w.size() == 0) chk("unexpected_w", WDATA, 32'hFFFF_FFFF);
                else begin
                    e36 = exp_w.pop_front();
                    chk("wdata", WDATA, e36[35:4]);
                    chk("wstrb", {28'd0, WSTRB}, {28'd0, e36[3:0]});
                end
            end
            if (axi_rvalid_o && !prev_rv) begin
                if (exp_r.size() == 0) chk("unexpected_rtag", axi_raddr_o, 32'hFFFF_FFFF);
                else begin
                    e64 = exp_r.pop_front();
                    chk("rtag_addr", axi_raddr_o, e64[63:32]);
                    chk("rtag_data", axi_rdata_o, e64[31:0]);
                end
            end
            if (axi_wvalid_o && !prev_wv) begin
                if (exp_b.size() == 0) chk("unexpected_wtag", axi_waddr_o, 32'hFFFF_FFFF);
                else begin
                    e68 = exp_b.pop_front();
                    chk("wtag_addr", axi_waddr_o, e68[67:36]);
                    chk("wtag_data", axi_wdata_o, e68[35:4]);
                    chk("wtag_web", {28'd0, axi_web_o}, {28'd0, e68[3:0]});
                end
            end
        end
        prev_rv = axi_rvalid_o;
        prev_wv = axi_wvalid_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input string name);
        int n = 0;
        while (!axi_rvalid_o && n < 20) begin tick(); n++; end
        chk(name, {31'd0, axi_rvalid_o}, 32'd1);
    endtask

    task automatic wait_wv(input string name);
        int n = 0;
        while (!axi_wvalid_o && n < 20) begin tick(); n++; end
        chk(name, {31'd0, axi_wvalid_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0;
        rst = 1'b1;
        mem_mem_read_i = 0; mem_mem_store_i = 0; pipe_advance_i = 0;
        mem_alu_result_i = 0; mem_mem_wdata_i = 0; mem_mem_web_i = 4'hF;
        RID = 4'd1; BID = 4'd1; RLAST = 1'b1; RRESP = 2'b00; BRESP = 2'b10;
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0; RDATA = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state and constant fields
        chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("rst_rready",  {31'd0, RREADY},  32'd0);
        chk("rst_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("rst_wvalid",  {31'd0, WVALID},  32'd0);
        chk("rst_bready",  {31'd0, BREADY},  32'd0);
        chk("rst_rvalid_tag", {31'd0, axi_rvalid_o}, 32'd0);
        chk("rst_wvalid_tag", {31'd0, axi_wvalid_o}, 32'd0);
        chk("rst_web", {28'd0, axi_web_o}, 32'hF);
        chk("rst_raddr", axi_raddr_o, 32'd0);
        chk("const_ax", {ARLEN, ARSIZE, ARBURST, AWLEN, AWSIZE, AWBURST, WLAST, ARID, AWID},
            {4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 1'b1, 4'd1, 4'd1});

        // Load 0x100, zero-wait slave
        r_data = 32'hDEAD_BEEF;
        mem_mem_read_i = 1; mem_alu_result_i = 32'h100;
        exp_ar.push_back(32'h100);
        exp_r.push_back({32'h100, 32'hDEAD_BEEF});
        tick();
        chk("ld1_c1_arvalid", {31'd0, ARVALID}, 32'd1);
        chk("ld1_c1_rready",  {31'd0, RREADY},  32'd0);
        tick();
        chk("ld1_c2_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("ld1_c2_rready",  {31'd0, RREADY},  32'd1);
        tick();
        chk("ld1_c3_rvalid", {31'd0, axi_rvalid_o}, 32'd1);
        tick();
        pipe_advance_i = 1;
        tick();
        pipe_advance_i = 0; mem_mem_read_i = 0;
        chk("ld1_c5_cleared", {31'd0, axi_rvalid_o}, 32'd0);
        chk("ld1_c5_addr_kept", axi_raddr_o, 32'h100);

        // Store 0x200, AWREADY 2 cycles late, WREADY immediate
        aw_delay = 2;
        mem_mem_store_i = 1; mem_alu_result_i = 32'h200;
        mem_mem_wdata_i = 32'h1234_5678; mem_mem_web_i = 4'b1100;
        exp_aw.push_back(32'h200);
        exp_w.push_back({32'h1234_5678, 4'b0011});
        exp_b.push_back({32'h200, 32'h1234_5678, 4'b1100});
        tick();
        chk("st_c1_aw_w", {30'd0, AWVALID, WVALID}, 32'b11);
        tick();
        chk("st_c2_aw_w", {30'd0, AWVALID, WVALID}, 32'b10);
        tick();
        chk("st_c3_aw_w", {30'd0, AWVALID, WVALID}, 32'b10);
        tick();
        chk("st_c4_aw_w", {30'd0, AWVALID, WVALID}, 32'b00);
        chk("st_c4_bready", {31'd0, BREADY}, 32'd1);
        wait_wv("st_wvalid_tag");
        mem_mem_store_i = 0; pipe_advance_i = 1;
        tick();
        pipe_advance_i = 0;
        chk("st_cleared", {31'd0, axi_wvalid_o}, 32'd0);
        aw_delay = 0;

        // Two loads from 0x100 separated by a pipeline advance
        ar0 = ar_hs;
        r_data = 32'hCAFE_0000;
        mem_mem_read_i = 1; mem_alu_result_i = 32'h100;
        exp_ar.push_back(32'h100);
        exp_r.push_back({32'h100, 32'hCAFE_0000});
        wait_rv("ld2a_rvalid");
        pipe_advance_i = 1; r_data = 32'h0000_0001;
        exp_ar.push_back(32'h100);
        exp_r.push_back({32'h100, 32'h0000_0001});
        tick();
        pipe_advance_i = 0;
        chk("ld2_between_cleared", {31'd0, axi_rvalid_o}, 32'd0);
        wait_rv("ld2b_rvalid");
        pipe_advance_i = 1; mem_mem_read_i = 0;
        tick();
        pipe_advance_i = 0;
        chk("ld2_ar_count", ar_hs - ar0, 32'd2);

        // Load dropped after its AR handshake still completes
        ar0 = ar_hs;
        r_data = 32'hA5A5_0300;
        mem_mem_read_i = 1; mem_alu_result_i = 32'h300;
        exp_ar.push_back(32'h300);
        exp_r.push_back({32'h300, 32'hA5A5_0300});
        tick();
        tick();
        mem_mem_read_i = 0; mem_alu_result_i = 32'h0;
        wait_rv("drop_rvalid");
        tick(); tick();
        chk("drop_ar_count", ar_hs - ar0, 32'd1);
        chk("drop_tag_kept", {31'd0, axi_rvalid_o}, 32'd1);
        pipe_advance_i = 1;
        tick();
        pipe_advance_i = 0;
        chk("drop_cleared", {31'd0, axi_rvalid_o}, 32'd0);

        // Reset while waiting on R
        r_en = 1'b0;
        mem_mem_read_i = 1; mem_alu_result_i = 32'h400;
        exp_ar.push_back(32'h400);
        tick();
        tick();
        chk("rstmid_rready_before", {31'd0, RREADY}, 32'd1);
        rst = 1; mem_mem_read_i = 0;
        tick();
        rst = 0; r_en = 1'b1;
        chk("rstmid_rready", {31'd0, RREADY}, 32'd0);
        chk("rstmid_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("rstmid_rvalid_tag", {31'd0, axi_rvalid_o}, 32'd0);
        chk("rstmid_raddr", axi_raddr_o, 32'd0);

        // Load and store together: only the load issues
        r_data = 32'h0000_0005;
        mem_mem_read_i = 1; mem_mem_store_i = 1; mem_alu_result_i = 32'h500;
        mem_mem_wdata_i = 32'h5555_AAAA; mem_mem_web_i = 4'b0000;
        exp_ar.push_back(32'h500);
        exp_r.push_back({32'h500, 32'h0000_0005});
        tick();
        chk("both_c1_ar_aw", {30'd0, ARVALID, AWVALID}, 32'b10);
        tick();
        chk("both_c2_aw", {30'd0, AWVALID, WVALID}, 32'b00);
        wait_rv("both_rvalid");
        mem_mem_read_i = 0; mem_mem_store_i = 0; pipe_advance_i = 1;
        tick();
        pipe_advance_i = 0;
        repeat (3) tick();

        chk("total_ar", ar_hs, 32'd6);
        chk("total_aw", aw_hs, 32'd1);
        chk("total_w",  w_hs,  32'd1);
        chk("left_ar", exp_ar.size(), 32'd0);
        chk("left_aw", exp_aw.size(), 32'd0);
        chk("left_w",  exp_w.size(),  32'd0);
        chk("left_r",  exp_r.size(),  32'd0);
        chk("left_b",  exp_b.size(),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
